// File: rtl/dcache_pkg.sv
// Shared encodings for the dcache/icache AXI read arbiter.
package dcache_pkg;

   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_SLVERR = 2'b10;
   localparam logic [1:0] AXI_DECERR = 2'b11;
   localparam logic [1:0] AXI_INCR   = 2'b01;

   localparam logic [3:0] DEF_ID0 = 4'b0000;
   localparam logic [3:0] DEF_ID1 = 4'b0001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == AXI_SLVERR) || (resp == AXI_DECERR);
   endfunction

endpackage

// File: rtl/dcache_axi_rd_arb_rr_arb2.sv
// Two-way round-robin grant; the pointer moves past the owner on completion.
module rr_arb2 (
   input  logic clock,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   input  logic cpl,
   input  logic cpl_gnt,
   output logic gnt,
   output logic ptr
);

   logic ptr_d;

   // after a burst completes the other requester becomes favoured
   assign ptr_d = cpl ? ~cpl_gnt : ptr;

   dff_ar #(.W(1)) u_ptr (.clock(clock), .reset(reset), .d(ptr_d), .q(ptr));

   // a lone requester wins outright; a tie goes to the pointer
   assign gnt = (req0 & req1) ? ptr : req1;

endmodule

// File: rtl/dff_ar.sv
// Async-reset D flip-flop, resets to zero.
module dff_ar #(
   parameter int W = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // plain register with asynchronous clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) q <= '0;
      else       q <= d;
   end

endmodule

// File: rtl/dcache_axi_rd_arb.sv
// Shares one AXI4 read channel between the dcache (0) and icache (1) fill engines.
module dcache_axi_rd_arb
   import dcache_pkg::*;
#(
   parameter int         ADDR_W = 64,
   parameter int         DATA_W = 128,
   parameter logic [3:0] ID0    = DEF_ID0,
   parameter logic [3:0] ID1    = DEF_ID1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              s0_arvalid,
   input  logic [ADDR_W-1:0] s0_araddr,
   input  logic [7:0]        s0_arlen,
   input  logic [2:0]        s0_arsize,
   input  logic [1:0]        s0_arburst,
   output logic              s0_arready,
   output logic              s0_rvalid,
   output logic [DATA_W-1:0] s0_rdata,
   output logic [1:0]        s0_rresp,
   output logic              s0_rlast,
   input  logic              s0_rready,
   input  logic              s1_arvalid,
   input  logic [ADDR_W-1:0] s1_araddr,
   input  logic [7:0]        s1_arlen,
   input  logic [2:0]        s1_arsize,
   input  logic [1:0]        s1_arburst,
   output logic              s1_arready,
   output logic              s1_rvalid,
   output logic [DATA_W-1:0] s1_rdata,
   output logic [1:0]        s1_rresp,
   output logic              s1_rlast,
   input  logic              s1_rready,
   output logic              m_arvalid,
   output logic [ADDR_W-1:0] m_araddr,
   output logic [3:0]        m_arid,
   output logic [7:0]        m_arlen,
   output logic [2:0]        m_arsize,
   output logic [1:0]        m_arburst,
   input  logic              m_arready,
   input  logic              m_rvalid,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [1:0]        m_rresp,
   input  logic              m_rlast,
   input  logic [3:0]        m_rid,
   output logic              m_rready,
   output logic              rd_err,
   output logic              busy
);

   // state | meaning
   // IDLE  | no burst owned; arbitrate among pending requests
   // ADDR  | AR of the granted requester presented to memory
   // DATA  | R beats steered to the granted requester until rlast

   state_t     state_q, state_d;
   logic [1:0] state_raw;
   logic       grant_q, grant_d;
   logic       arb_gnt, rr_ptr;
   logic [7:0] beat_cnt, len_q;
   logic       err_q;
   logic       any_req, beat_hs, cpl, beat_err, in_addr, in_data;
   logic [3:0] gid;

   dff_ar #(.W(2)) u_state (.clock(clock), .reset(reset), .d(state_d), .q(state_raw));
   dff_ar #(.W(1)) u_grant (.clock(clock), .reset(reset), .d(grant_d), .q(grant_q));

   assign state_q = state_t'(state_raw);

   rr_arb2 u_rr (
      .clock   (clock),
      .reset   (reset),
      .req0    (s0_arvalid),
      .req1    (s1_arvalid),
      .cpl     (cpl),
      .cpl_gnt (grant_q),
      .gnt     (arb_gnt),
      .ptr     (rr_ptr)
   );

   assign any_req = s0_arvalid | s1_arvalid;
   assign in_addr = (state_q == ST_ADDR);
   assign in_data = (state_q == ST_DATA);
   assign gid     = grant_q ? ID1 : ID0;
   assign beat_hs = in_data & m_rvalid & m_rready;
   assign cpl     = beat_hs & m_rlast;
   // rlast must coincide exactly with the beat whose count equals arlen
   assign beat_err = (m_rid != gid) | resp_is_err(m_rresp) | (m_rlast != (beat_cnt == len_q));

   // next-state and grant selection
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      case (state_q)
         ST_IDLE: if (any_req) begin
            grant_d = arb_gnt;
            state_d = ST_ADDR;
         end
         ST_ADDR: if (m_arready) state_d = ST_DATA;
         ST_DATA: if (cpl) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // burst length capture, beat counting and sticky error
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         beat_cnt <= '0;
         len_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         if ((state_q == ST_IDLE) && any_req) begin
            len_q    <= arb_gnt ? s1_arlen : s0_arlen;
            beat_cnt <= '0;
         end else if (beat_hs && (beat_cnt != 8'hFF)) begin
            beat_cnt <= beat_cnt + 8'd1;
         end
         if (beat_hs && beat_err) err_q <= 1'b1;
      end
   end

   assign m_arvalid  = in_addr;
   assign m_araddr   = grant_q ? s1_araddr  : s0_araddr;
   assign m_arlen    = grant_q ? s1_arlen   : s0_arlen;
   assign m_arsize   = grant_q ? s1_arsize  : s0_arsize;
   assign m_arburst  = grant_q ? s1_arburst : s0_arburst;
   assign m_arid     = gid;
   assign s0_arready = in_addr & ~grant_q & m_arready;
   assign s1_arready = in_addr &  grant_q & m_arready;

   assign m_rready  = in_data & (grant_q ? s1_rready : s0_rready);
   assign s0_rvalid = in_data & ~grant_q & m_rvalid;
   assign s1_rvalid = in_data &  grant_q & m_rvalid;
   assign s0_rlast  = m_rlast & s0_rvalid;
   assign s1_rlast  = m_rlast & s1_rvalid;
   assign s0_rdata  = m_rdata;
   assign s1_rdata  = m_rdata;
   assign s0_rresp  = m_rresp;
   assign s1_rresp  = m_rresp;

   assign busy   = (state_q != ST_IDLE);
   assign rd_err = err_q;

endmodule

// File: doc/dcache_axi_rd_arb.md
# dcache_axi_rd_arb

Two-requester arbiter that shares one AXI4 read channel (AR + R) between the data-cache line-fill engine and the instruction-cache line-fill engine. It sits between the two fill blocks and the memory-side AXI port. It grants one burst at a time in round-robin order and steers R beats back to the owner. It also checks beat count, ID and response, and flags protocol errors on a sticky output.

## Interface
Parameters:
- ADDR_W, 64, AR address width
- DATA_W, 128, R data width
- ID0, 4'b0000, AXI ID stamped on requester-0 bursts
- ID1, 4'b0001, AXI ID stamped on requester-1 bursts

Ports:
- clock  in  1  single clock; all logic rising-edge
- reset  in  1  reset, asynchronous, active-high
- sN_arvalid  in  1  requester N (N=0 dcache, 1 icache) address valid
- sN_araddr  in  ADDR_W  burst address
- sN_arlen  in  8  beats-1
- sN_arsize  in  3  beat size
- sN_arburst  in  2  burst type
- sN_arready  out  1  address accepted
- sN_rvalid  out  1  beat valid to requester N
- sN_rdata  out  DATA_W  beat data (broadcast to both)
- sN_rresp  out  2  beat response (broadcast)
- sN_rlast  out  1  last beat
- sN_rready  in  1  requester N ready
- m_arvalid  out  1  memory-side AR channel
- m_araddr  out  ADDR_W  memory-side AR channel
- m_arid  out  4  memory-side AR channel
- m_arlen  out  8  memory-side AR channel
- m_arsize  out  3  memory-side AR channel
- m_arburst  out  2  memory-side AR channel
- m_arready  in  1  memory-side AR channel
- m_rvalid  in  1  memory-side R channel
- m_rdata  in  DATA_W  memory-side R channel
- m_rresp  in  2  memory-side R channel
- m_rlast  in  1  memory-side R channel
- m_rid  in  4  memory-side R channel
- m_rready  out  1  memory-side R channel
- rd_err  out  1  sticky protocol/response error
- busy  out  1  a burst is granted and not yet complete

## Operation
- FSM states: IDLE, ADDR, DATA.
- Only one burst is outstanding at a time.
- Registers: grant (1b), rr_ptr (1b, the favoured requester), beat_cnt (8b), len_q (8b), err_q.
- IDLE:
  - If exactly one sN_arvalid is high, grant = N.
  - If both are high, grant = rr_ptr.
  - Latch len_q from the granted requester's arlen, clear beat_cnt, then go to ADDR.
  - No arready is returned in IDLE.
- ADDR:
  - m_ar* is driven combinationally from the granted requester; m_arid = ID0 or ID1 according to grant.
  - m_arvalid = 1. sG_arready = m_arready; the other requester's arready = 0.
  - Go to DATA when m_arready is high.
- DATA:
  - m_rready = sG_rready; sG_rvalid = m_rvalid; the other requester's rvalid = 0.
  - On each beat handshake (m_rvalid & m_rready), beat_cnt increments.
  - Exit when the handshake has m_rlast = 1: go to IDLE and set rr_ptr = ~grant.
- Error checks, evaluated on each beat handshake. err_q is set (and stays set until reset) on any of:
  - m_rid ≠ granted ID;
  - m_rresp ∈ {2'b10, 2'b11};
  - m_rlast = 1 while beat_cnt ≠ len_q;
  - m_rlast = 0 while beat_cnt = len_q.
- Errors do not alter sequencing: rlast alone ends the burst.
- Outputs outside the relevant state:
  - m_arvalid = 0, m_rready = 0 and all sN_arready / sN_rvalid = 0.
  - sN_rlast = m_rlast gated by sN_rvalid.
- busy = (state ≠ IDLE).
- rd_err = err_q.

## Timing
- Reset values: state IDLE, grant 0, rr_ptr 0, beat_cnt 0, len_q 0, err_q 0.
  - Therefore every valid/ready output = 0, busy = 0 and rd_err = 0.
- Arbitration latency: exactly 1 cycle.
  - If sN_arvalid rises in cycle t, the earliest m_arvalid is t+1.
  - The earliest sN_arready is t+1, when m_arready = 1.
- Requesters must hold arvalid and the AR fields stable until arready; a requester that drops arvalid in ADDR is a protocol violation and is not checked.
- Burst-to-burst turnaround: the cycle after the rlast handshake is IDLE, so the minimum gap between two AR issues is 1 cycle.
- R path is combinational in both directions; no added latency and no buffering.
- Simultaneous requests in IDLE: rr_ptr decides.
- A request arriving during ADDR or DATA waits; it is never dropped.
- reset asserted mid-burst returns to IDLE immediately.
  - Memory-side beats still in flight are the system's responsibility; reset is global.
- beat_cnt saturates at 255; it never wraps.

## Structure
- Shared package dcache_pkg holds:
  - AXI encodings: OKAY, EXOKAY, SLVERR, DECERR, INCR;
  - the FSM state encodings;
  - the default ID constants.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with pointer update on a completion strobe.
- State and pointer flops use the team's async-reset D flip-flop (dff_ar) with 0 reset value.

## Test plan
- Single req0 burst, arlen = 15, m_arready delayed 2 cycles, 16 beats with rlast on the 16th:
  - m_arid = 0000; s0 receives 16 rvalid; s1_rvalid stays 0; rd_err = 0; busy falls the cycle after rlast.
- s0/s1 arvalid both high from reset:
  - req0 granted first (rr_ptr = 0); req1 issues on the first IDLE after req0's rlast, with m_arid = 0001; a third simultaneous request goes to req0.
- Backpressure: s1_rready low for 3 cycles mid-burst:
  - m_rready low for the same 3 cycles; beat_cnt unchanged; no beat lost.
- Early rlast (beat 10 of arlen = 15):
  - burst ends, FSM returns to IDLE; rd_err = 1 and stays 1 across a subsequent clean burst.
- Bad rid (0010) or rresp = 2'b10 on any beat:
  - rd_err = 1; data is still forwarded.
- reset pulsed during DATA at beat 5:
  - all outputs 0 in the same cycle; after release, a new req1 burst completes normally with rd_err = 0.
